// File: rtl/ika2151_pkg.sv
// Shared constants and types for the IKA2151 bus/timing front end.
// Holds register address map, control/status bit positions, bus widths,
// the status-byte payload struct and its packing helper.
package ika2151_pkg;

    localparam int unsigned BUSY_LEN_DEFAULT = 64;

    localparam int unsigned SLOT_W  = 5;
    localparam int unsigned PRESC_W = 4;
    localparam int unsigned TMRA_W  = 10;
    localparam int unsigned TMRB_W  = 8;

    // Register address map
    localparam logic [7:0] ADDR_KON   = 8'h08;
    localparam logic [7:0] ADDR_CLKA1 = 8'h10;
    localparam logic [7:0] ADDR_CLKA2 = 8'h11;
    localparam logic [7:0] ADDR_CLKB  = 8'h12;
    localparam logic [7:0] ADDR_CTRL  = 8'h14;
    localparam logic [7:0] ADDR_LFRQ  = 8'h18;
    localparam logic [7:0] ADDR_CTW   = 8'h1B;

    // Timer control register (0x14) bit positions
    localparam int unsigned CTRL_LOADA   = 0;
    localparam int unsigned CTRL_LOADB   = 1;
    localparam int unsigned CTRL_FLAGENA = 2;
    localparam int unsigned CTRL_FLAGENB = 3;
    localparam int unsigned CTRL_RSTA    = 4;
    localparam int unsigned CTRL_RSTB    = 5;

    // Status byte bit positions
    localparam int unsigned STAT_FLAGA = 0;
    localparam int unsigned STAT_FLAGB = 1;
    localparam int unsigned STAT_BUSY  = 7;

    typedef struct packed {
        logic       busy;
        logic [4:0] rsvd;
        logic       flag_b;
        logic       flag_a;
    } status_t;

    function automatic status_t pack_status(input logic busy, input logic flag_b,
                                            input logic flag_a);
        status_t s;
        s        = '0;
        s.busy   = busy;
        s.flag_b = flag_b;
        s.flag_a = flag_a;
        return s;
    endfunction

endpackage

// File: rtl/ika2151_timer.sv
// Reloadable up-counter used for timers A and B.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   tick_i     count enable (one pulse per timer tick)
//   load_en_i  0: counter held at reload_i; 1: counter runs
//   reload_i   reload value
//   ovf_o      one-clock pulse, registered, when the counter passes all-ones
module ika2151_timer
    import ika2151_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tick_i,
    input  logic         load_en_i,
    input  logic [W-1:0] reload_i,
    output logic         ovf_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    // Next count: hold at reload while disabled, wrap to reload on overflow
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (!load_en_i) begin
            cnt_d = reload_i;
        end else if (tick_i) begin
            if (&cnt_q) begin
                cnt_d = reload_i;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;

endmodule

// File: rtl/ika2151.sv
// IKA2151 bus, register-file and timing front end (top: ika2151_core).
// Ports:
//   i_EMUCLK        system clock, all logic on rising edge
//   i_IC            synchronous active-high reset
//   i_phiM_PCEN_n   phiM clock enable, active-low
//   o_phi1          phiM/2
//   i_CS_n/i_RD_n/i_WR_n/i_A0/i_D   CPU bus (A0=0 address, A0=1 data)
//   o_D             status {busy, 5'b0, flagB, flagA}
//   o_CTRL_OE_n     data bus output enable (combinational)
//   o_SH1/o_SH2     DAC sample/hold strobes
// Optional: define IKA2151_DEBUG_EN to add i_DBG_ADDR/o_DBG_DATA, a
// combinational read port into the register file.
module ika2151_core
    import ika2151_pkg::*;
#(
    parameter int unsigned BUSY_LEN = BUSY_LEN_DEFAULT
) (
    input  logic       i_EMUCLK,
    input  logic       i_IC,
    input  logic       i_phiM_PCEN_n,
    output logic       o_phi1,
    input  logic       i_CS_n,
    input  logic       i_RD_n,
    input  logic       i_WR_n,
    input  logic       i_A0,
    input  logic [7:0] i_D,
    output logic [7:0] o_D,
    output logic       o_CTRL_OE_n,
    output logic       o_SH1,
    output logic       o_SH2
`ifdef IKA2151_DEBUG_EN
    ,
    input  logic [7:0] i_DBG_ADDR,
    output logic [7:0] o_DBG_DATA
`endif
);

    localparam int unsigned BUSY_W = $clog2(BUSY_LEN + 1);

    logic                phi1_q, phi1_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                sh1_q, sh1_d, sh2_q, sh2_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [BUSY_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic                flag_a_q, flag_a_d, flag_b_q, flag_b_d;
    status_t             stat_q, stat_d;
    logic [7:0]          addr_q, addr_d;
    logic                wr_prev_q;
    logic [7:0]          regs_q [256];

    logic                phi_en, slot_inc, sample_tick, tick_b;
    logic                wr_act, wr_evt, addr_wr, data_wr, ctrl_wr;
    logic                ovf_a, ovf_b;
    logic [TMRA_W-1:0]   na;
    logic [TMRB_W-1:0]   nb;

    // Timing strobes: slot advances on phi1 rising, wrap = one sample
    assign phi_en      = !i_phiM_PCEN_n;
    assign slot_inc    = phi_en && !phi1_q;
    assign sample_tick = slot_inc && (&slot_q);
    assign tick_b      = sample_tick && (&presc_q);

    // Write edge detect: one event per CS&WR assertion
    assign wr_act  = !i_CS_n && !i_WR_n;
    assign wr_evt  = wr_act && !wr_prev_q;
    assign addr_wr = wr_evt && !i_A0;
    assign data_wr = wr_evt && i_A0 && (busy_cnt_q == '0);
    assign ctrl_wr = data_wr && (addr_q == ADDR_CTRL);

    assign na = {regs_q[ADDR_CLKA1], regs_q[ADDR_CLKA2][1:0]};
    assign nb = regs_q[ADDR_CLKB];

    // Next-state for sequencer, busy, flags and status
    always_comb begin
        phi1_d     = phi1_q;
        slot_d     = slot_q;
        presc_d    = presc_q;
        busy_cnt_d = busy_cnt_q;
        flag_a_d   = flag_a_q;
        flag_b_d   = flag_b_q;
        addr_d     = addr_q;

        if (phi_en) begin
            phi1_d = !phi1_q;
        end
        if (slot_inc) begin
            slot_d = slot_q + SLOT_W'(1);
        end
        if (sample_tick) begin
            presc_d = presc_q + PRESC_W'(1);
        end

        if (addr_wr) begin
            addr_d = i_D;
        end

        if (data_wr) begin
            busy_cnt_d = BUSY_W'(BUSY_LEN);
        end else if (phi_en && (busy_cnt_q != '0)) begin
            busy_cnt_d = busy_cnt_q - BUSY_W'(1);
        end

        // Set first, then clear, so a reset write wins a coincident overflow
        if (ovf_a && regs_q[ADDR_CTRL][CTRL_FLAGENA]) begin
            flag_a_d = 1'b1;
        end
        if (ovf_b && regs_q[ADDR_CTRL][CTRL_FLAGENB]) begin
            flag_b_d = 1'b1;
        end
        if (ctrl_wr && i_D[CTRL_RSTA]) begin
            flag_a_d = 1'b0;
        end
        if (ctrl_wr && i_D[CTRL_RSTB]) begin
            flag_b_d = 1'b0;
        end

        // Strobes derived from the next slot so they line up with slot_q
        sh1_d  = (slot_d[4:3] == 2'b01);
        sh2_d  = (slot_d[4:3] == 2'b11);
        stat_d = pack_status(busy_cnt_d != '0, flag_b_d, flag_a_d);
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_IC) begin
            phi1_q     <= 1'b0;
            slot_q     <= '0;
            sh1_q      <= 1'b0;
            sh2_q      <= 1'b0;
            presc_q    <= '0;
            busy_cnt_q <= '0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            stat_q     <= '0;
            addr_q     <= '0;
        end else begin
            phi1_q     <= phi1_d;
            slot_q     <= slot_d;
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            presc_q    <= presc_d;
            busy_cnt_q <= busy_cnt_d;
            flag_a_q   <= flag_a_d;
            flag_b_q   <= flag_b_d;
            stat_q     <= stat_d;
            addr_q     <= addr_d;
        end
        // Tracks the strobe even in reset so a strobe held across reset
        // does not produce a write afterwards
        wr_prev_q <= wr_act;
    end

    // Register file
    always_ff @(posedge i_EMUCLK) begin
        if (i_IC) begin
            for (int i = 0; i < 256; i++) begin
                regs_q[i] <= '0;
            end
        end else if (data_wr) begin
            regs_q[addr_q] <= i_D;
        end
    end

    ika2151_timer #(.W(TMRA_W)) u_timer_a (
        .clk_i     (i_EMUCLK),
        .rst_i     (i_IC),
        .tick_i    (sample_tick),
        .load_en_i (regs_q[ADDR_CTRL][CTRL_LOADA]),
        .reload_i  (na),
        .ovf_o     (ovf_a)
    );

    ika2151_timer #(.W(TMRB_W)) u_timer_b (
        .clk_i     (i_EMUCLK),
        .rst_i     (i_IC),
        .tick_i    (tick_b),
        .load_en_i (regs_q[ADDR_CTRL][CTRL_LOADB]),
        .reload_i  (nb),
        .ovf_o     (ovf_b)
    );

    assign o_phi1      = phi1_q;
    assign o_SH1       = sh1_q;
    assign o_SH2       = sh2_q;
    assign o_D         = stat_q;
    assign o_CTRL_OE_n = !(!i_CS_n && !i_RD_n);

`ifdef IKA2151_DEBUG_EN
    assign o_DBG_DATA = regs_q[i_DBG_ADDR];
`endif

endmodule

// File: tb/tb_ika2151_core.sv
// Self-checking bench for ika2151_core: directed sequence plus random
// phiM spacing and random bus traffic, checked each clock against a
// behavioural model derived from phiM counts and register contents.
module tb_ika2151_core;

    localparam int BUSY_LEN = 64;

    logic       clk    = 1'b0;
    logic       ic     = 1'b1;
    logic       pcen_n = 1'b1;
    logic       cs_n   = 1'b1;
    logic       rd_n   = 1'b1;
    logic       wr_n   = 1'b1;
    logic       a0     = 1'b0;
    logic [7:0] din    = 8'h00;
    logic       phi1, oe_n, sh1, sh2;
    logic [7:0] dout;
`ifdef IKA2151_DEBUG_EN
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         n;          // phiM enables since reset
    int         busy_left;  // phiM enables of busy remaining
    int         gap;
    int         cnt_a, cnt_b;
    logic [7:0] m_addr;
    logic [7:0] m_regs [256];
    logic       m_fa, m_fb, pend_a, pend_b, m_wr_prev;

    always #5 clk = ~clk;

    ika2151_core dut (
        .i_EMUCLK      (clk),
        .i_IC          (ic),
        .i_phiM_PCEN_n (pcen_n),
        .o_phi1        (phi1),
        .i_CS_n        (cs_n),
        .i_RD_n        (rd_n),
        .i_WR_n        (wr_n),
        .i_A0          (a0),
        .i_D           (din),
        .o_D           (dout),
        .o_CTRL_OE_n   (oe_n),
        .o_SH1         (sh1),
        .o_SH2         (sh2)
`ifdef IKA2151_DEBUG_EN
        ,
        .i_DBG_ADDR    (dbg_addr),
        .o_DBG_DATA    (dbg_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int samples();
        return ((n + 1) / 2) / 32;
    endfunction

    // One rising edge of the reference model, using the inputs present at that edge
    task automatic model_edge();
        logic       wr_act, evt, acc, set_a, set_b, clr_a, clr_b, wrap, tick_b;
        logic [7:0] ctrl;
        int         na, nb;
        wr_act = !cs_n && !wr_n;
        if (ic) begin
            n = 0; busy_left = 0; m_addr = 8'h00;
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_fa = 1'b0; m_fb = 1'b0; pend_a = 1'b0; pend_b = 1'b0;
            cnt_a = 0; cnt_b = 0; m_wr_prev = wr_act;
            return;
        end
        ctrl = m_regs[8'h14];
        na   = int'({m_regs[8'h10], m_regs[8'h11][1:0]});
        nb   = int'(m_regs[8'h12]);
        wrap = 1'b0; tick_b = 1'b0;
        if (!pcen_n) begin
            n++;
            // slot = ceil(n/2) mod 32; a sample ends when it returns to 0
            if ((n % 2) == 1 && (((n + 1) / 2) % 32) == 0) begin
                wrap   = 1'b1;
                tick_b = ((((n + 1) / 2) / 32) % 16) == 0;
            end
        end
        // Flags follow an overflow by one clock
        set_a = pend_a && ctrl[2];
        set_b = pend_b && ctrl[3];
        pend_a = 1'b0; pend_b = 1'b0;
        if (!ctrl[0]) cnt_a = na;
        else if (wrap) begin
            cnt_a++;
            if (cnt_a > 1023) begin cnt_a = na; pend_a = 1'b1; end
        end
        if (!ctrl[1]) cnt_b = nb;
        else if (tick_b) begin
            cnt_b++;
            if (cnt_b > 255) begin cnt_b = nb; pend_b = 1'b1; end
        end
        evt = wr_act && !m_wr_prev;
        m_wr_prev = wr_act;
        acc = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        if (evt && !a0) m_addr = din;
        else if (evt && busy_left == 0) begin
            acc = 1'b1;
            m_regs[m_addr] = din;
            if (m_addr == 8'h14) begin clr_a = din[4]; clr_b = din[5]; end
        end
        if (acc) busy_left = BUSY_LEN;
        else if (!pcen_n && busy_left > 0) busy_left--;
        if (clr_a) m_fa = 1'b0; else if (set_a) m_fa = 1'b1;
        if (clr_b) m_fb = 1'b0; else if (set_b) m_fb = 1'b1;
    endtask

    // Advance one clock with random phiM spacing and check every output
    task automatic step();
        int         slot;
        logic [7:0] exp_d;
        if (gap == 0) begin pcen_n = 1'b0; gap = int'($urandom_range(2, 1)); end
        else begin pcen_n = 1'b1; gap--; end
        @(posedge clk); #1;
        model_edge();
        slot  = ((n + 1) / 2) % 32;
        exp_d = {busy_left != 0, 5'b00000, m_fb, m_fa};
        chk("phi1",   32'(phi1), 32'(n % 2));
        chk("sh1",    32'(sh1),  32'(slot >= 8 && slot <= 15));
        chk("sh2",    32'(sh2),  32'(slot >= 24));
        chk("status", 32'(dout), 32'(exp_d));
        chk("oe_n",   32'(oe_n), 32'(!(!cs_n && !rd_n)));
        @(negedge clk);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic write_begin(input logic a, input logic [7:0] d);
        a0 = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
        step();
    endtask

    task automatic write_end();
        step();
        cs_n = 1'b1; wr_n = 1'b1;
        step();
    endtask

    task automatic write(input logic a, input logic [7:0] d);
        write_begin(a, d);
        write_end();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy_left != 0; i++) step();
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
`ifdef IKA2151_DEBUG_EN
        dbg_addr = a; #1; v = dbg_data;
`else
        v = dut.regs_q[a];
`endif
    endtask

    initial begin
        logic [7:0] v;
        int         w0, n0, d, op;
        gap = 0;
        @(negedge clk);
        run(80);
        ic = 1'b0;
        chk("reset_status", 32'(dout), 32'h00);
        chk("reset_phi1",   32'(phi1), 32'h0);
        chk("reset_sh",     32'({sh1, sh2}), 32'h0);
        chk("reset_oe_n",   32'(oe_n), 32'h1);

        // Free run: phi1 / slot / SH strobes
        run(400);
        chk("idle_status", 32'(dout), 32'h00);

        // Data write then status read: busy for exactly BUSY_LEN phiM
        write(1'b0, 8'h18);
        write_begin(1'b1, 8'hFF);
        n0 = n;
        chk("busy_set", 32'(dout[7]), 32'h1);
        step();
        wr_n = 1'b1; rd_n = 1'b0;
        for (int i = 0; i < 400 && dout[7]; i++) step();
        chk("busy_len", 32'(n - n0), 32'(BUSY_LEN));
        chk("read_oe_n", 32'(oe_n), 32'h0);
        cs_n = 1'b1; rd_n = 1'b1;
        step();
        read_reg(8'h18, v);
        chk("reg18", 32'(v), 32'hFF);

        // Second data write while busy is dropped
        write(1'b0, 8'h1B);
        write(1'b1, 8'h01);
        write(1'b0, 8'h28);
        write(1'b1, 8'h4E);
        read_reg(8'h1B, v);
        chk("reg1B", 32'(v), 32'h01);
        read_reg(8'h28, v);
        chk("reg28_dropped", 32'(v), 32'h00);
        wait_idle();

        // Timer A at NA=1023: overflows on every sample
        write(1'b0, 8'h10); write(1'b1, 8'hFF); wait_idle();
        write(1'b0, 8'h11); write(1'b1, 8'h03); wait_idle();
        write(1'b0, 8'h14);
        write_begin(1'b1, 8'h05);
        w0 = samples();
        write_end();
        for (int i = 0; i < 600 && !dout[0]; i++) step();
        chk("flagA_set",   32'(dout[0]), 32'h1);
        chk("flagA_delay", 32'(samples() - w0), 32'h1);
        run(300);
        wait_idle();
        write_begin(1'b1, 8'h15);
        chk("flagA_clear", 32'(dout[0]), 32'h0);
        write_end();
        run(250);
        chk("flagA_again", 32'(dout[0]), 32'h1);
        wait_idle();

        // Timer B at NB=255: first prescaler tick overflows
        write(1'b0, 8'h12); write(1'b1, 8'hFF); wait_idle();
        write(1'b0, 8'h14);
        write_begin(1'b1, 8'h0A);
        w0 = samples();
        write_end();
        for (int i = 0; i < 4000 && !dout[1]; i++) step();
        d = samples() - w0;
        chk("flagB_set",      32'(dout[1]), 32'h1);
        chk("flagB_delay_ok", 32'(d >= 1 && d <= 16), 32'h1);
        chk("flagA_kept",     32'(dout[0]), 32'h1);
        wait_idle();
        write_begin(1'b1, 8'h22);
        chk("flagB_clear",  32'(dout[1]), 32'h0);
        chk("flagA_intact", 32'(dout[0]), 32'h1);
        write_end();
        wait_idle();

        // Reset in the middle of a busy write with flagA set
        write(1'b0, 8'h30);
        write_begin(1'b1, 8'h5A);
        chk("pre_reset_status", 32'(dout), 32'h81);
        ic = 1'b1;
        step();
        ic = 1'b0;
        chk("post_reset_status", 32'(dout), 32'h00);
        chk("post_reset_phi1",   32'(phi1), 32'h0);
        cs_n = 1'b1; wr_n = 1'b1;
        step();
        read_reg(8'h30, v); chk("post_reset_reg30", 32'(v), 32'h00);
        read_reg(8'h14, v); chk("post_reset_reg14", 32'(v), 32'h00);
        read_reg(8'h18, v); chk("post_reset_reg18", 32'(v), 32'h00);

        // Random bus traffic
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(3, 0));
            case (op)
                0: write(1'b0, 8'($urandom));
                1: write(1'b1, 8'($urandom));
                2: begin
                    cs_n = 1'b0; rd_n = 1'b0;
                    run(int'($urandom_range(4, 1)));
                    cs_n = 1'b1; rd_n = 1'b1;
                    step();
                end
                default: run(int'($urandom_range(90, 0)));
            endcase
        end
        for (int a = 0; a < 256; a++) begin
            read_reg(8'(a), v);
            chk("regfile", 32'(v), 32'(m_regs[a]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
